// File: rtl/pbit_pkg.sv
// Shared types and constants for the p-bit sweep scheduler.
//   sweep_state_t : scheduler FSM states
//   BETA_W/BETA_MAX : inverse-temperature register width and ceiling
//   beta_sat_add  : saturating add used by the annealing schedule
package pbit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

    localparam int unsigned           BETA_W   = 8;
    localparam logic [BETA_W-1:0]     BETA_MAX = 8'hFF;

    // Add with clamp at BETA_MAX instead of wrapping.
    function automatic logic [BETA_W-1:0] beta_sat_add(
        input logic [BETA_W-1:0] a,
        input logic [BETA_W-1:0] b
    );
        logic [BETA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[BETA_W] ? BETA_MAX : sum[BETA_W-1:0];
    endfunction

endpackage

// File: rtl/pbit_settle_timer.sv
// Loadable down-counter that times the idle gap after each accepted update.
// Ports:
//   clk, reset     : clock, async active-low reset
//   load, load_val : load the counter (load_val = gap length minus one)
//   en             : count down while not yet expired
//   expired        : registered flag, high once the counter has reached zero
module pbit_settle_timer
    import pbit_pkg::*;
#(
    parameter int unsigned CNT_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    // Expired is registered alongside the count so the FSM sees no comb path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            expired <= 1'b1;
        end else if (load) begin
            count   <= load_val;
            expired <= (load_val == '0);
        end else if (en && !expired) begin
            count   <= count - CNT_W'(1);
            expired <= (count == CNT_W'(1));
        end
    end

endmodule

// File: rtl/pbit_sweep_sched.sv
// Gibbs-sweep sequencer for a p-bit array. Issues one update per p-bit in
// index order, each with a freshly captured random word, inserts a settle gap
// after every accepted update, and repeats for num_sweeps sweeps.
// Ports:
//   clk, reset            : clock, async active-low reset
//   start, num_sweeps     : begin a run (ignored when busy or num_sweeps == 0)
//   abort                 : end the current run immediately, no done
//   rand_in               : free-running RNG word
//   upd_valid/upd_ready   : update handshake to the p-bit datapath
//   upd_idx, upd_rand     : p-bit index and random word of the pending update
//   busy, done, sweep_cnt : status; done is a one-cycle completion pulse
// Optional feature: define PBIT_SWEEP_SCHED_ANNEAL_EN to add beta_init,
// beta_step and the beta annealing output.
module pbit_sweep_sched
    import pbit_pkg::*;
#(
    parameter  int unsigned N_PBITS = 8,
    parameter  int unsigned RAND_W  = 8,
    parameter  int unsigned SWEEP_W = 16,
    parameter  int unsigned SETTLE  = 2,
    localparam int unsigned IDX_W   = (N_PBITS > 1) ? $clog2(N_PBITS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [SWEEP_W-1:0] num_sweeps,
    input  logic [RAND_W-1:0]  rand_in,
    output logic               upd_valid,
    input  logic               upd_ready,
    output logic [IDX_W-1:0]   upd_idx,
    output logic [RAND_W-1:0]  upd_rand,
    output logic               busy,
    output logic               done,
    output logic [SWEEP_W-1:0] sweep_cnt
`ifdef PBIT_SWEEP_SCHED_ANNEAL_EN
    ,
    input  logic [BETA_W-1:0]  beta_init,
    input  logic [BETA_W-1:0]  beta_step,
    output logic [BETA_W-1:0]  beta
`endif
);

    localparam int unsigned      CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned      SETTLE_LOAD = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_PBITS - 1);
    localparam logic             NO_GAP      = (SETTLE == 0);

    sweep_state_t       state;
    logic [SWEEP_W-1:0] sweeps_lat;
    logic               timer_load;
    logic               timer_en;
    logic               timer_expired;
    logic               accept_c;
    logic               step_c;
    logic               last_idx_c;
    logic               run_end_c;
    logic [SWEEP_W-1:0] sweep_inc_c;

`ifdef PBIT_SWEEP_SCHED_ANNEAL_EN
    logic [BETA_W-1:0]  beta_step_lat;
`endif

    // Settle-gap timer; loaded with SETTLE-1 so SETTLE cycles elapse in ST_SETTLE.
    pbit_settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (CNT_W'(SETTLE_LOAD)),
        .en       (timer_en),
        .expired  (timer_expired)
    );

    // Handshake acceptance and next-update step decode; abort always wins.
    always_comb begin
        last_idx_c  = (upd_idx == LAST_IDX);
        sweep_inc_c = sweep_cnt + SWEEP_W'(1);
        run_end_c   = last_idx_c && (sweep_inc_c == sweeps_lat);
        accept_c    = (state == ST_ISSUE) && upd_ready && !abort;
        timer_load  = accept_c && !NO_GAP;
        timer_en    = (state == ST_SETTLE);
        step_c      = (accept_c && NO_GAP)
                   || ((state == ST_SETTLE) && timer_expired && !abort);
    end

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            sweeps_lat <= '0;
            upd_valid  <= 1'b0;
            upd_idx    <= '0;
            upd_rand   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sweep_cnt  <= '0;
`ifdef PBIT_SWEEP_SCHED_ANNEAL_EN
            beta          <= '0;
            beta_step_lat <= '0;
`endif
        end else begin
            done <= 1'b0;

            if (abort && (state != ST_IDLE)) begin
                state     <= ST_IDLE;
                upd_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && (num_sweeps != '0)) begin
                            state      <= ST_ISSUE;
                            sweeps_lat <= num_sweeps;
                            upd_idx    <= '0;
                            sweep_cnt  <= '0;
                            upd_rand   <= rand_in;
                            upd_valid  <= 1'b1;
                            busy       <= 1'b1;
`ifdef PBIT_SWEEP_SCHED_ANNEAL_EN
                            beta          <= beta_init;
                            beta_step_lat <= beta_step;
`endif
                        end
                    end
                    ST_ISSUE: begin
                        if (upd_ready && !NO_GAP) begin
                            state     <= ST_SETTLE;
                            upd_valid <= 1'b0;
                        end
                    end
                    ST_SETTLE: begin
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state     <= ST_IDLE;
                        upd_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end

            // Next-update step: advance index, close a sweep on wrap.
            if (step_c) begin
                if (last_idx_c) begin
                    upd_idx   <= '0;
                    sweep_cnt <= sweep_inc_c;
`ifdef PBIT_SWEEP_SCHED_ANNEAL_EN
                    beta      <= beta_sat_add(beta, beta_step_lat);
`endif
                end else begin
                    upd_idx <= upd_idx + IDX_W'(1);
                end

                if (run_end_c) begin
                    state     <= ST_DONE;
                    done      <= 1'b1;
                    upd_valid <= 1'b0;
                end else begin
                    state     <= ST_ISSUE;
                    upd_valid <= 1'b1;
                    upd_rand  <= rand_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_pbit_sweep_sched.sv
// Directed bench for pbit_sweep_sched (N_PBITS=4, SETTLE=2). Expected update
// indices are queued when a run is launched and popped on every accepted
// handshake; random words and hold stability are checked cycle by cycle.
module tb_pbit_sweep_sched;

    localparam int unsigned N_PBITS = 4;
    localparam int unsigned RAND_W  = 8;
    localparam int unsigned SWEEP_W = 16;
    localparam int unsigned SETTLE  = 2;
    localparam int unsigned IDX_W   = 2;

    logic               clk;
    logic               reset;
    logic               start;
    logic               abort;
    logic [SWEEP_W-1:0] num_sweeps;
    logic [RAND_W-1:0]  rand_in;
    logic               upd_valid;
    logic               upd_ready;
    logic [IDX_W-1:0]   upd_idx;
    logic [RAND_W-1:0]  upd_rand;
    logic               busy;
    logic               done;
    logic [SWEEP_W-1:0] sweep_cnt;
`ifdef PBIT_SWEEP_SCHED_ANNEAL_EN
    logic [7:0]         beta_init;
    logic [7:0]         beta_step;
    logic [7:0]         beta;
`endif

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int v0       = 0;
    int exp_q[$];

    pbit_sweep_sched #(
        .N_PBITS (N_PBITS),
        .RAND_W  (RAND_W),
        .SWEEP_W (SWEEP_W),
        .SETTLE  (SETTLE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .num_sweeps (num_sweeps),
        .rand_in    (rand_in),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_idx    (upd_idx),
        .upd_rand   (upd_rand),
        .busy       (busy),
        .done       (done),
        .sweep_cnt  (sweep_cnt)
`ifdef PBIT_SWEEP_SCHED_ANNEAL_EN
        ,
        .beta_init  (beta_init),
        .beta_step  (beta_step),
        .beta       (beta)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_run(input int sweeps);
        for (int s = 0; s < sweeps; s++)
            for (int i = 0; i < int'(N_PBITS); i++)
                exp_q.push_back(i);
    endtask

    // One clock: score the handshake seen at this edge, then sample at negedge.
    task automatic tick();
        logic             acc;
        logic             pv;
        logic [IDX_W-1:0] pidx;
        logic [RAND_W-1:0] prand;
        logic [RAND_W-1:0] launch;
        int               e;
        acc = upd_valid && upd_ready && !abort && reset;
        if (acc) begin
            if (exp_q.size() == 0) begin
                chk("idx_unexpected", 32'(upd_idx), 32'hEE);
            end else begin
                e = exp_q.pop_front();
                chk("upd_idx", 32'(upd_idx), 32'(e));
            end
        end
        pv     = upd_valid;
        pidx   = upd_idx;
        prand  = upd_rand;
        launch = rand_in;
        @(posedge clk);
        #1 rand_in = RAND_W'($urandom);
        @(negedge clk);
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (upd_valid && (!pv || acc)) begin
            chk("upd_rand", 32'(upd_rand), 32'(launch));
        end else if (upd_valid && pv && !acc) begin
            chk("hold_idx", 32'(upd_idx), 32'(pidx));
            chk("hold_rand", 32'(upd_rand), 32'(prand));
        end
    endtask

    task automatic wait_idx(input int idx);
        int n = 0;
        while (!(upd_valid && upd_idx == IDX_W'(idx)) && n < 200) begin
            tick();
            n++;
        end
        chk("wait_idx", 32'(upd_valid && upd_idx == IDX_W'(idx)), 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        num_sweeps = '0;
        rand_in    = 8'h5A;
        upd_ready  = 1'b0;
`ifdef PBIT_SWEEP_SCHED_ANNEAL_EN
        beta_init  = '0;
        beta_step  = '0;
`endif
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_valid", 32'(upd_valid), 32'd0);
        chk("rst_idx",   32'(upd_idx),   32'd0);
        chk("rst_rand",  32'(upd_rand),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_sweep", 32'(sweep_cnt), 32'd0);
        reset = 1'b1;
        tick();

        // Basic run: 2 sweeps, always ready
        upd_ready  = 1'b1;
        num_sweeps = 16'd2;
        done_cnt   = 0;
        push_run(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_lat", 32'(upd_valid), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        v0 = cyc;
        wait_done();
        chk("run_len", 32'(done_cyc - v0), 32'd24);
        chk("basic_sweep", 32'(sweep_cnt), 32'd2);
        tick();
        chk("done_pulse", 32'(done), 32'd0);
        chk("basic_idle", 32'(busy), 32'd0);
        chk("basic_done_cnt", 32'(done_cnt), 32'd1);
        chk("basic_q_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure on idx 2 with a start pulse while busy
        num_sweeps = 16'd1;
        done_cnt   = 0;
        push_run(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idx(2);
        upd_ready  = 1'b0;
        num_sweeps = 16'd5;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("bp_valid", 32'(upd_valid), 32'd1);
        chk("bp_idx", 32'(upd_idx), 32'd2);
        upd_ready  = 1'b1;
        num_sweeps = 16'd1;
        wait_done();
        chk("bp_sweep", 32'(sweep_cnt), 32'd1);
        tick();
        chk("bp_done_cnt", 32'(done_cnt), 32'd1);
        chk("bp_q_empty", 32'(exp_q.size()), 32'd0);

        // Start with zero sweeps is ignored
        done_cnt   = 0;
        num_sweeps = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_valid", 32'(upd_valid), 32'd0);
        repeat (3) tick();
        chk("zero_no_done", 32'(done_cnt), 32'd0);
        chk("zero_sweep_hold", 32'(sweep_cnt), 32'd1);

        // Abort colliding with ready on idx 1 of sweep 0
        num_sweeps = 16'd1;
        exp_q.push_back(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idx(1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(upd_valid), 32'd0);
        chk("abort_sweep", 32'(sweep_cnt), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (3) tick();
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_q_empty", 32'(exp_q.size()), 32'd0);

        // Async reset while in the settle gap
        exp_q.push_back(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre_rst_settle", 32'({busy, upd_valid}), 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 32'(upd_valid), 32'd0);
        chk("arst_idx",   32'(upd_idx),   32'd0);
        chk("arst_rand",  32'(upd_rand),  32'd0);
        chk("arst_busy",  32'(busy),      32'd0);
        chk("arst_done",  32'(done),      32'd0);
        chk("arst_sweep", 32'(sweep_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("arst_stays_idle", 32'(busy), 32'd0);
        chk("arst_q_empty", 32'(exp_q.size()), 32'd0);

`ifdef PBIT_SWEEP_SCHED_ANNEAL_EN
        // Annealing schedule with saturation
        begin
            int bexp[4] = '{250, 254, 255, 255};
            int n;
            beta_init  = 8'd250;
            beta_step  = 8'd4;
            num_sweeps = 16'd3;
            push_run(3);
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("beta_s0", 32'(beta), 32'(bexp[0]));
            for (int s = 1; s <= 3; s++) begin
                n = 0;
                while (sweep_cnt != SWEEP_W'(s) && n < 200) begin
                    tick();
                    n++;
                end
                chk("beta_sweep", 32'(beta), 32'(bexp[s]));
            end
            wait_done();
            tick();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pbit_sweep_sched.md
# pbit_sweep_sched

Sequencer for a p-bit array: issues one update per p-bit in index order and repeats for a programmed number of Gibbs sweeps. Each update carries a fresh random word sampled from the shared LFSR-based RNG. A settle gap follows every accepted update so the neighbouring p-bit inputs see the new state before the next update. Sits between the host/start logic and the p-bit datapath; it is the only block that drives p-bit update enables.

## Interface
- `N_PBITS`, default 8: number of p-bits; index width `IDX_W = $clog2(N_PBITS)`, minimum 1.
- `RAND_W`, default 8: width of the random word passed to the datapath.
- `SWEEP_W`, default 16: width of the sweep count.
- `SETTLE`, default 2: idle cycles after each accepted update; 0 is legal.
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low (asserted at 0).
- `start`, input, 1: pulse; begins a run when IDLE and `num_sweeps != 0`.
- `abort`, input, 1: ends a run immediately.
- `num_sweeps`, input, SWEEP_W: sweeps per run; sampled on the accepted `start`.
- `rand_in`, input, RAND_W: free-running RNG output.
- `upd_valid`, output, 1: update request to the datapath.
- `upd_ready`, input, 1: datapath accepts the update.
- `upd_idx`, output, IDX_W: p-bit index being updated.
- `upd_rand`, output, RAND_W: random word for this update.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse when a run completes normally.
- `sweep_cnt`, output, SWEEP_W: number of completed sweeps in the current or last run.

## Operation
- States: IDLE, ISSUE, SETTLE, DONE.
- **IDLE**
  - `start` and `num_sweeps != 0`: latch `num_sweeps`, clear `upd_idx` and `sweep_cnt`, capture `rand_in` into `upd_rand`, go to ISSUE.
  - `start` with `num_sweeps == 0`: ignored; no `done`.
- **ISSUE**
  - `upd_valid = 1`; `upd_idx` and `upd_rand` are held stable until the update is accepted.
  - `upd_ready` high: the update is accepted. Go to SETTLE, or go straight to the next-update step when `SETTLE == 0`.
- **SETTLE**
  - Counts `SETTLE` cycles, then performs the next-update step.
- **Next-update step**
  - If `upd_idx == N_PBITS-1`: wrap `upd_idx` to 0 and increment `sweep_cnt`. If the new `sweep_cnt` equals the latched count, go to DONE.
  - Otherwise: increment `upd_idx`.
  - When not going to DONE: capture a new `rand_in`, return to ISSUE.
- **DONE**
  - `done = 1` for one cycle, then IDLE. `sweep_cnt` holds its value until the next accepted `start`.
- **abort**
  - In any non-IDLE state, go to IDLE next cycle with no `done`. `sweep_cnt` is frozen.
  - `abort` and `upd_ready` in the same cycle: `abort` wins and the update does not count.
- `start` while `busy`: ignored.
- Arithmetic:
  - `upd_idx` wraps modulo `N_PBITS`; it never takes values ≥ `N_PBITS` (non-power-of-two sizes included).
  - `sweep_cnt` cannot overflow, because it stops at the latched count.

## Timing
- Reset values:
  - `upd_valid=0`, `upd_idx=0`, `upd_rand=0`, `busy=0`, `done=0`, `sweep_cnt=0`; state IDLE.
- Latencies:
  - `start` to first `upd_valid`: 1 cycle.
  - Accepted update to next `upd_valid`: `SETTLE+1` cycles.
- A run with always-ready datapath takes `num_sweeps*N_PBITS*(SETTLE+1)` cycles from the first `upd_valid` to `done`.
- `upd_rand` is registered: it is the `rand_in` value one cycle before `upd_valid` rises.
- All outputs are registered. No combinational path from `upd_ready` to any output.
- Reset asserted mid-run: all outputs go to reset values asynchronously, and the run is lost.

## Configuration
- `PBIT_SWEEP_SCHED_ANNEAL_EN` defined: adds these ports.
  - `beta_init` (8, input) and `beta_step` (8, input): sampled on the accepted `start`.
  - `beta` (8, output): loads `beta_init` at start and adds `beta_step` at each sweep increment, saturating at 255. Reset value 0.
- Undefined: none of these ports or registers exist; behaviour is otherwise identical.

## Structure
- Shared package `pbit_pkg`:
  - state enum `sweep_state_t`;
  - constants `BETA_W=8` and `BETA_MAX=8'hFF`.
- One sub-module, `pbit_settle_timer`: loadable down-counter with a `expired` flag, used for the SETTLE gap.

## Test plan
- Basic run: N=4, SETTLE=2, `num_sweeps=2`, `upd_ready` tied 1 → `upd_idx` sequence 0,1,2,3,0,1,2,3; `done` pulses once, 24 cycles after the first `upd_valid`; `sweep_cnt=2`.
- Backpressure: hold `upd_ready=0` for 5 cycles on idx 2 → `upd_valid`, `upd_idx=2` and `upd_rand` stay stable for all 5 cycles; the sequence continues at idx 3.
- Zero and busy start: `start` with `num_sweeps=0` → `busy` stays 0 and no `done`; `start` pulsed mid-run → no effect on `upd_idx`.
- Abort collision: assert `abort` and `upd_ready` together on idx 1 of sweep 0 → next cycle IDLE, `sweep_cnt=0`, `upd_valid=0`, no `done`.
- Async reset mid-run: drive `reset=0` between clock edges during SETTLE → outputs reach reset values before the next edge.
- Anneal (macro defined): `beta_init=250`, `beta_step=4`, `num_sweeps=3` → `beta` takes 250, 254, 255, 255.
